// File: rtl/onehot_dec_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// onehot_dec_pkg : shared widths, FSM states and 3-to-8 helper for the decoder
// Revision: 1.0
// ---------------------------------------------------------------------------
package onehot_dec_pkg;

   localparam int IDX_W = 3;
   localparam int DEC_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   function automatic logic [DEC_W-1:0] onehot3to8(input logic [IDX_W-1:0] idx);
      return DEC_W'(1) << idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_pulse_decoder_dec3to8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dec3to8 : combinational 3-to-8 one-hot decoder with enable
// Revision: 1.0
// ---------------------------------------------------------------------------
import onehot_dec_pkg::*;

module dec3to8 (
   input  logic             en,
   input  logic [IDX_W-1:0] idx,
   output logic [DEC_W-1:0] y
);

   assign y = en ? onehot3to8(idx) : '0;

endmodule
`default_nettype wire

// File: rtl/onehot_pulse_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// onehot_pulse_decoder : handshaked index to timed one-hot pulse plus gap
// Revision: 1.0
// ---------------------------------------------------------------------------
import onehot_dec_pkg::*;

module onehot_pulse_decoder #(
   parameter int HOLD_CYCLES = 2,
   parameter int GAP_CYCLES  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [IDX_W-1:0] idx,
   input  logic             idx_valid,
   output logic             idx_ready,
   output logic [DEC_W-1:0] dec_out,
   output logic             done,
   output logic [DEC_W-1:0] seen,
   input  logic             seen_clr
);

   localparam int c_max_cyc = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int c_cnt_w   = (c_max_cyc > 2) ? $clog2(c_max_cyc) : 1;
   localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_gap_load  = c_cnt_w'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

   state_t             r_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [IDX_W-1:0]   r_idx;
   logic [DEC_W-1:0]   r_dec;
   logic               r_done;
   logic [DEC_W-1:0]   r_seen;

   logic               w_ready;
   logic               w_accept;
   logic               w_dec_en;
   logic [IDX_W-1:0]   w_dec_idx;
   logic [DEC_W-1:0]   w_dec;
   logic               w_done_next;
   logic [DEC_W-1:0]   w_seen_next;

   assign w_ready  = en && (r_state == IDLE);
   assign w_accept = w_ready && idx_valid;

   // One decoder serves both the next pulse value and the seen update:
   // on accept it decodes the incoming index, otherwise the captured one.
   assign w_dec_idx = w_accept ? idx : r_idx;
   assign w_dec_en  = w_accept || (en && (r_state == HOLD) && (r_cnt != '0));

   dec3to8 u_dec (
      .en  (w_dec_en),
      .idx (w_dec_idx),
      .y   (w_dec)
   );

   // done is registered, so it is raised on the edge entering the last HOLD cycle
   assign w_done_next = (w_accept && (HOLD_CYCLES == 1)) ||
                        (en && (r_state == HOLD) && (r_cnt == c_one));

   assign w_seen_next = (seen_clr ? '0 : r_seen) | (w_accept ? w_dec : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_dec   <= '0;
         r_done  <= 1'b0;
         r_seen  <= '0;
      end else begin
         r_dec  <= w_dec;
         r_done <= w_done_next;
         r_seen <= w_seen_next;
         if (!en) begin
            r_state <= IDLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (idx_valid) begin
                     r_idx   <= idx;
                     r_cnt   <= c_hold_load;
                     r_state <= HOLD;
                  end
               end
               HOLD: begin
                  if (r_cnt != '0) begin
                     r_cnt <= r_cnt - c_one;
                  end else if (GAP_CYCLES == 0) begin
                     r_state <= IDLE;
                  end else begin
                     r_cnt   <= c_gap_load;
                     r_state <= GAP;
                  end
               end
               GAP: begin
                  if (r_cnt != '0) begin
                     r_cnt <= r_cnt - c_one;
                  end else begin
                     r_state <= IDLE;
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign idx_ready = w_ready;
   assign dec_out   = r_dec;
   assign done      = r_done;
   assign seen      = r_seen;

endmodule
`default_nettype wire

// File: tb/tb_onehot_pulse_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_onehot_pulse_decoder : two parameterisations against a timeline model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_onehot_pulse_decoder;

   localparam int H0 = 2, G0 = 1;
   localparam int H1 = 1, G1 = 0;

   logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, idx_valid = 1'b0, seen_clr = 1'b0;
   logic [2:0] idx = 3'd0;
   logic       rdy0, done0, rdy1, done1;
   logic [7:0] dec0, seen0, dec1, seen1;

   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   onehot_pulse_decoder #(.HOLD_CYCLES(H0), .GAP_CYCLES(G0)) dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .idx(idx), .idx_valid(idx_valid),
      .idx_ready(rdy0), .dec_out(dec0), .done(done0), .seen(seen0), .seen_clr(seen_clr));

   onehot_pulse_decoder #(.HOLD_CYCLES(H1), .GAP_CYCLES(G1)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .idx(idx), .idx_valid(idx_valid),
      .idx_ready(rdy1), .dec_out(dec1), .done(done1), .seen(seen1), .seen_clr(seen_clr));

   // Model: m_t counts cycles since accept (0 = idle); pulse occupies 1..H, gap H+1..H+G.
   int         m_t[2]    = '{0, 0};
   int         m_line[2] = '{0, 0};
   logic [7:0] m_seen[2] = '{8'h00, 8'h00};
   int         mh, mg;
   bit         macc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_t[k] = 0;
            m_seen[k] = 8'h00;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            mh = (k == 0) ? H0 : H1;
            mg = (k == 0) ? G0 : G1;
            macc = en && (m_t[k] == 0) && idx_valid;
            if (seen_clr) m_seen[k] = 8'h00;
            if (macc) m_seen[k][idx] = 1'b1;
            if (!en) m_t[k] = 0;
            else if (macc) begin
               m_t[k] = 1;
               m_line[k] = int'(idx);
            end else if (m_t[k] != 0) m_t[k] = (m_t[k] >= mh + mg) ? 0 : m_t[k] + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_dec(input int k, input int h);
      logic [7:0] one;
      one = 8'h01;
      return (m_t[k] >= 1 && m_t[k] <= h) ? (one << m_line[k]) : 8'h00;
   endfunction

   task automatic check_all();
      chk("dec0",  dec0,  exp_dec(0, H0));
      chk("done0", {7'd0, done0}, {7'd0, m_t[0] == H0});
      chk("rdy0",  {7'd0, rdy0},  {7'd0, en && m_t[0] == 0});
      chk("seen0", seen0, m_seen[0]);
      chk("dec1",  dec1,  exp_dec(1, H1));
      chk("done1", {7'd0, done1}, {7'd0, m_t[1] == H1});
      chk("rdy1",  {7'd0, rdy1},  {7'd0, en && m_t[1] == 0});
      chk("seen1", seen1, m_seen[1]);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      en = 1'b1;
      #2;
      chk("rst_dec", dec0, 8'h00);
      chk("rst_seen", seen0, 8'h00);
      step();
      rst_n = 1'b1;
      step();
      chk("rdy_after_rst", {7'd0, rdy0}, 8'h01);

      // basic pulse of line 5
      idx = 3'd5; idx_valid = 1'b1;
      step();
      idx_valid = 1'b0;
      chk("p5_t1", dec0, 8'h20);
      step();
      chk("p5_done", {7'd0, done0}, 8'h01);
      step();
      chk("p5_gap", dec0, 8'h00);
      step();
      chk("p5_ready", {7'd0, rdy0}, 8'h01);
      chk("p5_seen", seen0, 8'h20);

      // back-to-back with valid held high
      seen_clr = 1'b1;
      step();
      seen_clr = 1'b0;
      idx = 3'd0; idx_valid = 1'b1;
      step();
      idx = 3'd7;
      for (int i = 0; i < 5; i++) step();
      idx_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("b2b_seen", seen0, 8'h81);

      // en dropped during first HOLD cycle; held valid must wait
      idx = 3'd2; idx_valid = 1'b1;
      step();
      chk("en_drop_pre", dec0, 8'h04);
      en = 1'b0; idx = 3'd6;
      step();
      chk("en_drop_dec", dec0, 8'h00);
      chk("en_drop_rdy", {7'd0, rdy0}, 8'h00);
      step();
      en = 1'b1;
      step();
      chk("en_back_dec", dec0, 8'h40);
      idx_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();

      // build seen = F0, then clear coinciding with accept of 1
      seen_clr = 1'b1;
      step();
      seen_clr = 1'b0;
      for (int i = 4; i < 8; i++) begin
         idx = 3'(i); idx_valid = 1'b1;
         step();
         idx_valid = 1'b0;
         for (int j = 0; j < 3; j++) step();
      end
      chk("seen_f0", seen0, 8'hF0);
      idx = 3'd1; idx_valid = 1'b1; seen_clr = 1'b1;
      step();
      idx_valid = 1'b0; seen_clr = 1'b0;
      chk("clr_and_set", seen0, 8'h02);
      for (int i = 0; i < 3; i++) step();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         en        = ($urandom_range(0, 9) != 0);
         idx_valid = ($urandom_range(0, 2) != 0);
         idx       = 3'($urandom_range(0, 7));
         seen_clr  = ($urandom_range(0, 15) == 0);
         step();
      end

      // asynchronous reset mid-HOLD
      en = 1'b1; seen_clr = 1'b0; idx_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      idx = 3'd4; idx_valid = 1'b1;
      step();
      idx_valid = 1'b0;
      chk("arst_pre", dec0, 8'h10);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_dec", dec0, 8'h00);
      chk("arst_done", {7'd0, done0}, 8'h00);
      chk("arst_seen", seen0, 8'h00);
      chk("arst_dec1", dec1, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("arst_rdy", {7'd0, rdy0}, 8'h01);
      idx = 3'd3; idx_valid = 1'b1;
      step();
      idx_valid = 1'b0;
      chk("arst_cold", dec0, 8'h08);
      for (int i = 0; i < 3; i++) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
